// File: rtl/serial_subtractor_mux.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin, LSB first) built around a mux-based full-subtractor cell.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state  | meaning
  // IDLE   | waiting for start, result outputs hold last value
  // SHIFT  | one operand bit pair consumed per edge
  // DONE   | result valid, done pulse for one cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             x_bit, y_bit, sel, d_bit, br_nxt;
  logic [WIDTH-1:0] r_nxt;

  function automatic logic mux2(input logic s, input logic i0, input logic i1);
    return s ? i1 : i0;
  endfunction

  // Full-subtractor cell: every gate is a 2:1 mux, select = x ^ y.
  always_comb begin
    x_bit  = a_sh[0];
    y_bit  = b_sh[0];
    sel    = mux2(x_bit, y_bit, ~y_bit);
    d_bit  = mux2(sel, br, ~br);
    br_nxt = mux2(sel, br, y_bit);
    r_nxt  = {d_bit, r_sh[WIDTH-1:1]};
  end

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      r_sh <= '0;
      br   <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      r_sh <= r_nxt;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers only move on the final bit, so they hold across idle periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_bit) begin
      diff <= r_nxt;
      bout <= br_nxt;
    end
  end

`ifdef SUB_OVF_EN
  logic a_msb, b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      // d_bit on the final edge is the result MSB.
      if (last_bit) ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

// File: doc/serial_subtractor_mux.md
Name: serial_subtractor_mux

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first.
- Uses one 1-bit full-subtractor cell built from 2x1 muxes plus a borrow flop, iterated over WIDTH cycles.
- Companion to the mux-based full adder: subtraction direction, sequential, with a start/busy/done handshake.
- Sits between operand registers and the result consumer in the mux arithmetic set.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset: async on rst=1.
  - State IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE after WIDTH bit-cycles.
  - DONE -> IDLE unconditionally after one cycle.
- Accept edge (IDLE, start=1):
  - Latch a and b into shift registers; borrow flop <= bin; counter <= 0; busy <= 1.
  - diff and bout keep their previous values until the result is written.
- Each SHIFT edge, with bit pair x=a_sh[0], y=b_sh[0], borrow br:
  - d = x ^ y ^ br.
  - br' = (~x & y) | (~(x ^ y) & br). This is the mux form: select = x ^ y, input0 = br, input1 = y.
  - a_sh and b_sh shift right by one. The result shift register shifts right with d inserted at the MSB. Counter increments.
- Exactly WIDTH SHIFT edges. On the last one:
  - diff <= completed result register; bout <= final br'.
  - State -> DONE; busy <= 0; done <= 1.
- DONE lasts exactly one cycle. done returns to 0 on the next edge, with state back in IDLE.
- Latency: accept edge E0, result visible after edge E(WIDTH). done is high between E(WIDTH) and E(WIDTH+1). Next start is accepted at the earliest on E(WIDTH+2).
- start in SHIFT or DONE is ignored, not queued. Operand inputs are don't-care outside the accept edge.
- diff and bout hold their value from the last completed operation until the next one completes.
- rst asserted mid-operation aborts immediately to the reset state. No done pulse is produced for the aborted operation.
- Boundaries:
  - a == b with bin=0 gives diff=0, bout=0.
  - All-zero a and b with bin=1 gives all-ones diff, bout=1.
  - Wrap-around is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), signed two's-complement overflow of a - b - bin.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs. Captured together with diff/bout.
  - Reset value 0; holds between operations.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start one cycle -> busy high 8 cycles, done pulse at cycle 8 after accept, diff=0x1E, bout=0.
- a=0x3C, b=0x5A, bin=0 -> diff=0xE2, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x01, bin=0 -> diff=0xFE, bout=0.
- start held high continuously with new operands every cycle -> only one operation accepted per 10-cycle window. Operand changes during SHIFT do not affect diff. No second done within 9 cycles of the first.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, and with SUB_OVF_EN ovf=1. a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1. a=0x10, b=0x01 -> ovf=0.
- Accept a=0xAA, b=0x55; assert rst after 3 SHIFT cycles for 1 cycle -> busy=0, done=0, diff=0, bout=0 immediately, no done pulse. A subsequent start with a=0x01, b=0x01 gives diff=0x00, bout=0.
- Exhaustive 1-bit check at WIDTH=2: all 32 combinations of a, b, bin -> diff and bout match the reference model (a - b - bin) mod 4, and borrow = (a < b + bin).
